instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, instruction-memory word-address width.
REQ-002 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port o_imemReq  output  1  fetch request to instruction memory.
REQ-006 SHALL have port o_imemAddr  output  ADDR_W  word address of the request.
REQ-007 SHALL have port i_imemAck  input  1  memory returns data this cycle; ignored while o_imemReq=0.
REQ-008 SHALL have port i_imemData  input  16  instruction word; valid when i_imemAck=1.
REQ-009 SHALL have port o_instrCode  output  16  instruction to control/decode; opcode in [15:10].
REQ-010 SHALL have port o_instrPc  output  ADDR_W  address of o_instrCode.
REQ-011 SHALL have port o_instrValid  output  1  o_instrCode/o_instrPc valid.
REQ-012 SHALL have port i_instrReady  input  1  downstream accepts; pop on o_instrValid & i_instrReady.
REQ-013 SHALL have port i_redirect  input  1  one-cycle pulse: flush and refetch from i_redirectPc (branch/jump taken).
REQ-014 SHALL have port i_redirectPc  input  ADDR_W  redirect target, sampled when i_redirect=1.

Function
REQ-015 SHALL contain a 2-entry FIFO of {instruction, address}; o_instrCode/o_instrPc = head entry, o_instrValid = (count>0), all registered-state-derived.
REQ-016 SHALL use FSM states IDLE (no request outstanding), REQ (request outstanding, response kept), DROP (request outstanding, response discarded).
REQ-017 SHALL allow at most one outstanding request; o_imemReq=1 exactly in REQ and DROP.
REQ-018 SHALL hold o_imemAddr stable while o_imemReq=1 until the cycle i_imemAck=1; a request is never withdrawn.
REQ-019 IDLE -> REQ when count<2, with o_imemAddr = fetch PC, from the next cycle.
REQ-020 REQ on i_imemAck (no redirect): push {i_imemData, o_imemAddr}, fetch PC := o_imemAddr+1; stay REQ with new address if post-push/pop count<2, else IDLE (back-to-back fetch, 1 instruction/cycle with 0-wait memory).
REQ-021 Fetch PC SHALL increment modulo 2^ADDR_W (0xFFFF+1 = 0x0000 at default width).
REQ-022 Pop and push in same cycle SHALL both take effect; FIFO never overflows (push only with count<=1); pop on empty impossible since valid=0.
REQ-023 i_redirect SHALL have priority over push/pop: next cycle count=0, o_instrValid=0, fetch PC := i_redirectPc; an instruction handshaken in the redirect cycle counts as accepted.
REQ-024 Redirect in IDLE -> REQ at i_redirectPc next cycle.
REQ-025 Redirect in REQ without ack -> DROP; redirect in REQ or DROP with ack same cycle -> data discarded, REQ at i_redirectPc next cycle.
REQ-026 DROP on i_imemAck: discard data, -> REQ at fetch PC; a further redirect in DROP only updates fetch PC.
REQ-027 Instructions SHALL leave in address order with no loss or duplication between redirects.

Reset
REQ-028 While i_rst_n=0 (asynchronously): o_imemReq=0, o_instrValid=0, o_instrCode=0, o_instrPc=0, o_imemAddr=RESET_PC, FSM=IDLE, count=0, fetch PC=RESET_PC.
REQ-029 Reset mid-REQ/DROP SHALL abandon the outstanding request; acks during reset ignored; first request RESET_PC one cycle after release.

Verification
REQ-030 Reset release, 0-wait memory returning 16'h1000+addr, ready=1 -> addresses 0,1,2,... consecutive cycles; o_instrCode 0x1000,0x1001,... with matching o_instrPc.
REQ-031 i_instrReady=0 -> after addresses 0,1 buffered, o_imemReq=0, o_instrCode held 0x1000; ready=1 -> pops 0x1000,0x1001, fetch resumes at 2.
REQ-032 FIFO full, i_redirect with target 0x0040 -> o_instrValid=0 next cycle; next o_instrPc=0x0040, old entries never appear.
REQ-033 Ack latency 3, redirect to 0x0080 one cycle after request to 0x0005 -> 0x0005 held until ack, its data never output, then request 0x0080.
REQ-034 Redirect coincident with ack -> that data discarded; next o_imemAddr = target; RESET_PC=0xFFFF -> addresses 0xFFFF, 0x0000.
REQ-035 i_rst_n low while in REQ -> o_imemReq and o_instrValid fall without clock edge; restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch unit. Issues single-outstanding word fetches
//             to instruction memory, buffers up to two {instruction, address}
//             pairs in a small FIFO for the decoder, and flushes/refetches on
//             a branch or jump redirect.
//  Ports    : i_clk, i_rst_n       - clock, asynchronous active-low reset
//             o_imemReq/o_imemAddr - memory request and word address
//             i_imemAck/i_imemData - memory response (ignored when idle)
//             o_instrCode/o_instrPc/o_instrValid, i_instrReady
//                                  - instruction stream to decode
//             i_redirect/i_redirectPc - flush and refetch from new target
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imemReq,
  output logic [ADDR_W-1:0] o_imemAddr,
  input  logic              i_imemAck,
  input  logic [15:0]       i_imemData,
  output logic [15:0]       o_instrCode,
  output logic [ADDR_W-1:0] o_instrPc,
  output logic              o_instrValid,
  input  logic              i_instrReady,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirectPc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request outstanding, response will be kept
    DROP = 2'd2   // request outstanding, response will be discarded
  } state_t;

  localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state, w_stateNext;
  logic [ADDR_W-1:0] r_fetchPc, w_fetchPcNext;
  logic [ADDR_W-1:0] r_imemAddr, w_imemAddrNext;
  logic [1:0]        r_count, w_countNext, w_countAfterPop;
  logic              r_head, w_headNext;
  logic [15:0]       r_code [2];
  logic [ADDR_W-1:0] r_pc   [2];

  logic              w_pop;
  logic              w_ack;
  logic              w_push;
  logic              w_wrIdx;

  // Tail slot is head+count; a push only happens with count<=1, so bit 0
  // of the count is enough to select the free slot.
  assign w_wrIdx = r_head ^ r_count[0];

  always_comb begin
    w_stateNext     = r_state;
    w_fetchPcNext   = r_fetchPc;
    w_imemAddrNext  = r_imemAddr;
    w_push          = 1'b0;
    w_pop           = (r_count != 2'd0) && i_instrReady;
    w_ack           = (r_state != IDLE) && i_imemAck;
    w_countAfterPop = r_count - {1'b0, w_pop};
    w_headNext      = r_head;

    case (r_state)
      IDLE: begin
        // Address register already tracks the fetch PC while idle.
        if (w_countAfterPop < 2'd2) begin
          w_stateNext    = REQ;
          w_imemAddrNext = r_fetchPc;
        end
      end
      REQ: begin
        if (w_ack) begin
          w_push         = 1'b1;
          w_fetchPcNext  = r_imemAddr + c_one;
          w_imemAddrNext = r_imemAddr + c_one;
          // After this push the FIFO holds countAfterPop+1 entries; keep
          // streaming only if there is still room for the next response.
          w_stateNext    = (w_countAfterPop == 2'd0) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (w_ack) begin
          w_stateNext    = REQ;
          w_imemAddrNext = r_fetchPc;
        end
      end
      default: begin
        w_stateNext    = IDLE;
        w_imemAddrNext = r_fetchPc;
      end
    endcase

    if (!w_push && w_pop) begin
      w_headNext = ~r_head;
    end else if (w_pop) begin
      w_headNext = ~r_head;
    end

    w_countNext = w_countAfterPop + {1'b0, w_push};

    // Redirect wins over everything: flush the FIFO and retarget. A request
    // still waiting for its ack cannot be withdrawn, so it is marked for
    // discard and the target is parked in the fetch PC.
    if (i_redirect) begin
      w_push        = 1'b0;
      w_countNext   = 2'd0;
      w_fetchPcNext = i_redirectPc;
      if ((r_state != IDLE) && !w_ack) begin
        w_stateNext    = DROP;
        w_imemAddrNext = r_imemAddr;
      end else begin
        w_stateNext    = REQ;
        w_imemAddrNext = i_redirectPc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_fetchPc  <= RESET_PC;
      r_imemAddr <= RESET_PC;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_code[0]  <= 16'h0000;
      r_code[1]  <= 16'h0000;
      r_pc[0]    <= '0;
      r_pc[1]    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_fetchPc  <= w_fetchPcNext;
      r_imemAddr <= w_imemAddrNext;
      r_count    <= w_countNext;
      r_head     <= w_headNext;
      if (w_push) begin
        r_code[w_wrIdx] <= i_imemData;
        r_pc[w_wrIdx]   <= r_imemAddr;
      end
    end
  end

  assign o_imemReq    = (r_state != IDLE);
  assign o_imemAddr   = r_imemAddr;
  assign o_instrValid = (r_count != 2'd0);
  assign o_instrCode  = r_code[r_head];
  assign o_instrPc    = r_pc[r_head];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch: directed vector table,
//             hand-written redirect/reset sequences and a randomized run
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemData;
  logic [15:0] instrCode;
  logic [15:0] instrPc;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [15:0] redirectPc;

  // Second instance with a wrap-around reset PC, fed by a 0-wait memory.
  logic        req2;
  logic [15:0] addr2;
  logic        ack2;
  logic [15:0] data2;
  logic [15:0] code2;
  logic [15:0] pc2;
  logic        valid2;
  logic        ready2;
  logic        redirect2;
  logic [15:0] redirectPc2;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imemReq(imemReq), .o_imemAddr(imemAddr),
    .i_imemAck(imemAck), .i_imemData(imemData),
    .o_instrCode(instrCode), .o_instrPc(instrPc), .o_instrValid(instrValid),
    .i_instrReady(instrReady),
    .i_redirect(redirect), .i_redirectPc(redirectPc)
  );

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imemReq(req2), .o_imemAddr(addr2),
    .i_imemAck(ack2), .i_imemData(data2),
    .o_instrCode(code2), .o_instrPc(pc2), .o_instrValid(valid2),
    .i_instrReady(ready2),
    .i_redirect(redirect2), .i_redirectPc(redirectPc2)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int memWait = 0;
  int memLat  = 0;
  bit randLat = 1'b0;

  task automatic driveMem();
    imemAck  = imemReq && (memWait >= memLat);
    imemData = imemAck ? (16'h1000 + imemAddr) : 16'($urandom);
    ack2     = req2;
    data2    = 16'h1000 + addr2;
  endtask

  task automatic tick();
    logic reqS, ackS;
    reqS = imemReq;
    ackS = imemAck;
    @(posedge clk);
    if (!reqS || ackS || !rst_n) memWait = 0;
    else                         memWait++;
    if (ackS && randLat) memLat = $urandom_range(0, 3);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] code;
    logic [15:0] pc;
  } ent_t;

  ent_t        mq[$];
  bit          mBusy;
  bit          mDrop;
  logic [15:0] mAddr;
  logic [15:0] mFetch;

  task automatic modelReset(input logic [15:0] rpc);
    mq.delete();
    mBusy  = 1'b0;
    mDrop  = 1'b0;
    mAddr  = rpc;
    mFetch = rpc;
  endtask

  task automatic modelStep(input bit rdy, input bit rd, input logic [15:0] rpc,
                           input bit ak, input logic [15:0] dat);
    ent_t e;
    bit   ackSeen;
    ackSeen = mBusy && ak;
    if (rd) begin
      mq.delete();
      mFetch = rpc;
      if (mBusy && !ackSeen) begin
        mDrop = 1'b1;
      end else begin
        mBusy = 1'b1;
        mDrop = 1'b0;
        mAddr = rpc;
      end
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (ackSeen) begin
        if (!mDrop) begin
          e.code = dat;
          e.pc   = mAddr;
          mq.push_back(e);
          mFetch = mAddr + 16'd1;
        end
        mBusy = 1'b0;
        mDrop = 1'b0;
      end
      if (!mBusy && mq.size() < 2) begin
        mBusy = 1'b1;
        mAddr = mFetch;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          ready;
    bit          redir;
    logic [15:0] rpc;
    bit          eReq;
    logic [15:0] eAddr;
    bit          eValid;
    bit          chkData;
    logic [15:0] eCode;
    logic [15:0] ePc;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(bit rdy, bit rd, logic [15:0] rpc, bit rq, logic [15:0] a,
                              bit v, bit cd, logic [15:0] c, logic [15:0] p);
    vec_t t;
    t.ready = rdy; t.redir = rd; t.rpc = rpc; t.eReq = rq; t.eAddr = a;
    t.eValid = v; t.chkData = cd; t.eCode = c; t.ePc = p;
    return t;
  endfunction

  task automatic doReset();
    rst_n      = 1'b0;
    instrReady = 1'b0;
    redirect   = 1'b0;
    redirectPc = 16'h0000;
    imemAck    = 1'b0;
    imemData   = 16'h0000;
    ack2       = 1'b0;
    data2      = 16'h0000;
    repeat (3) @(negedge clk);
    memWait = 0;
    rst_n   = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ready2      = 1'b1;
    redirect2   = 1'b0;
    redirectPc2 = 16'h0000;

    //            rdy rd rpc       req addr     v  cd code      pc
    tbl[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 0, 16'h0000, 1, 16'h0000, 0, 1, 16'h0000, 16'h0000);
    tbl[2]  = mk(1, 0, 16'h0000, 1, 16'h0001, 1, 1, 16'h1000, 16'h0000);
    tbl[3]  = mk(1, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h1001, 16'h0001);
    tbl[4]  = mk(0, 0, 16'h0000, 1, 16'h0003, 1, 1, 16'h1002, 16'h0002);
    tbl[5]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1002, 16'h0002);
    tbl[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1002, 16'h0002);
    tbl[7]  = mk(1, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h1003, 16'h0003);
    tbl[8]  = mk(0, 0, 16'h0000, 1, 16'h0005, 1, 1, 16'h1004, 16'h0004);
    tbl[9]  = mk(0, 1, 16'h0040, 0, 16'h0000, 1, 1, 16'h1004, 16'h0004);
    tbl[10] = mk(1, 0, 16'h0000, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000);
    tbl[11] = mk(1, 0, 16'h0000, 1, 16'h0041, 1, 1, 16'h1040, 16'h0040);
    tbl[12] = mk(1, 1, 16'h0100, 1, 16'h0042, 1, 1, 16'h1041, 16'h0041);
    tbl[13] = mk(1, 0, 16'h0000, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000);
    tbl[14] = mk(1, 0, 16'h0000, 1, 16'h0101, 1, 1, 16'h1100, 16'h0100);
    tbl[15] = mk(1, 0, 16'h0000, 1, 16'h0102, 1, 1, 16'h1101, 16'h0101);

    // ---- Phase A: table, 0-wait memory ----
    randLat = 1'b0;
    memLat  = 0;
    @(negedge clk);
    doReset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tbl[%0d].req", i), imemReq, tbl[i].eReq);
      if (tbl[i].eReq || i == 0) check($sformatf("tbl[%0d].addr", i), imemAddr, tbl[i].eAddr);
      check($sformatf("tbl[%0d].valid", i), instrValid, tbl[i].eValid);
      if (tbl[i].chkData) begin
        check($sformatf("tbl[%0d].code", i), instrCode, tbl[i].eCode);
        check($sformatf("tbl[%0d].pc", i), instrPc, tbl[i].ePc);
      end
      if (i == 1) begin
        check("wrap.req0", req2, 1'b1);
        check("wrap.addr0", addr2, 16'hFFFF);
      end
      if (i == 2) begin
        check("wrap.addr1", addr2, 16'h0000);
        check("wrap.valid", valid2, 1'b1);
        check("wrap.code", code2, 16'h0FFF);
        check("wrap.pc", pc2, 16'hFFFF);
      end
      instrReady = tbl[i].ready;
      redirect   = tbl[i].redir;
      redirectPc = tbl[i].rpc;
      driveMem();
      tick();
    end
    redirect = 1'b0;

    // ---- Phase B: redirect while a 3-wait request is outstanding ----
    memLat = 3;
    doReset();
    instrReady = 1'b1;
    redirect   = 1'b1;
    redirectPc = 16'h0005;
    driveMem();
    tick();
    for (int s = 1; s <= 9; s++) begin
      if (s <= 4) begin
        check($sformatf("drop.s%0d.req", s), imemReq, 1'b1);
        check($sformatf("drop.s%0d.addr", s), imemAddr, 16'h0005);
      end
      if (s == 5) check("drop.retarget", imemAddr, 16'h0080);
      if (s <= 8) check($sformatf("drop.s%0d.valid", s), instrValid, 1'b0);
      if (s == 9) begin
        check("drop.valid", instrValid, 1'b1);
        check("drop.pc", instrPc, 16'h0080);
        check("drop.code", instrCode, 16'h1080);
      end
      redirect   = (s == 2);
      redirectPc = 16'h0080;
      driveMem();
      tick();
    end
    redirect = 1'b0;

    // ---- Phase C: asynchronous reset while streaming ----
    memLat = 0;
    repeat (3) begin
      driveMem();
      tick();
    end
    check("async.pre.req", imemReq, 1'b1);
    check("async.pre.valid", instrValid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async.req", imemReq, 1'b0);
    check("async.valid", instrValid, 1'b0);
    check("async.code", instrCode, 16'h0000);
    check("async.pc", instrPc, 16'h0000);
    check("async.addr", imemAddr, 16'h0000);
    @(negedge clk);
    driveMem();
    tick();
    memWait = 0;
    rst_n   = 1'b1;

    // ---- Phase D: randomized run against the reference model ----
    randLat = 1'b1;
    memLat  = $urandom_range(0, 3);
    modelReset(16'h0000);
    for (int c = 0; c < 3000; c++) begin
      check("rnd.req", imemReq, mBusy);
      if (mBusy) check("rnd.addr", imemAddr, mAddr);
      check("rnd.valid", instrValid, (mq.size() > 0));
      if (mq.size() > 0) begin
        check("rnd.code", instrCode, mq[0].code);
        check("rnd.pc", instrPc, mq[0].pc);
      end
      instrReady = ($urandom_range(0, 9) < 7);
      redirect   = ($urandom_range(0, 19) == 0);
      redirectPc = 16'($urandom);
      driveMem();
      modelStep(instrReady, redirect, redirectPc, imemAck, imemData);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
